oc8051_port_sampler: RTL and testbench
======================================

# oc8051_port_sampler

Input side of the 8051 parallel ports. Synchronizes raw pin levels of P0–P3 into the core clock domain, provides the stable values read by SFR/bit reads, and extracts the P3 alternate-function events: external interrupt flags IE0/IE1 (P3.2/P3.3, level or falling-edge mode per TCON.IT0/IT1) and counter-input strobes T0/T1 (P3.4/P3.5). It sits between the pad ring and the SFR read mux, the interrupt controller and the timer/counter block.

## Interface
- SYNC_STAGES, 2, synchronizer depth per pin bit (legal 2–3)
- clk  input  1  core clock; the block uses this single clock
- rst  input  1  reset; synchronous, active-high
- p0_pin, p1_pin, p2_pin, p3_pin  input  8 each  raw asynchronous pin levels
- p0_in, p1_in, p2_in, p3_in  output  8 each  synchronized pin values to the port/SFR read path
- it0, it1  input  1  TCON.IT0/IT1: 1 = falling-edge mode, 0 = level mode
- wr, wr_bit  input  1  SFR write strobe and bit-addressed qualifier
- wr_addr  input  8  SFR byte address, or bit address when wr_bit=1
- data_in  input  8  byte write data
- bit_in  input  1  bit write data
- ie0_ack, ie1_ack  input  1  single-cycle interrupt-vector acknowledge from the interrupt controller
- ie0, ie1  output  1  TCON.IE0/IE1 flags
- t0_event, t1_event  output  1  single-cycle strobe on falling edge of synchronized P3.4/P3.5

## Operation
- Each of the 32 pin bits passes through SYNC_STAGES flops; the last stage drives pN_in.
- An edge detector keeps one extra flop (prev) per monitored P3 bit (2,3,4,5); fall = prev & ~pN_in.
- t0_event = fall on P3.4; t1_event = fall on P3.5. These are pure strobes, never held.
- IE0 in edge mode (it0=1): set on fall(P3.2); cleared by ie0_ack; software-writable via TCON byte write (0x88, data_in[1]) or bit write (0x89, bit_in).
- IE0 in level mode (it0=0): ie0 register loads ~p3_in[2] every cycle; ack and software writes have no lasting effect (overwritten next cycle).
- IE1 identical using P3.3, it1, data_in[3], bit address 0x8B, ie1_ack.
- Priority per flag in edge mode, highest first: hardware set (fall), then ack clear, then software write, then hold. A fall and ack in the same cycle leave the flag at 1.
- Switching itN mid-operation takes effect on the next cycle; no flag is cleared by the switch itself.
- Other TCON bits, and writes to other addresses, are ignored by this block.

## Timing
- Reset (rst high at a clk edge): all sync stages and prev flops = 1 (ports reset high, matching P0–P3 reset value 0xFF); ie0=ie1=0; t0_event=t1_event=0. Therefore no spurious edge is seen after reset release.
- Pin-to-pN_in latency: exactly SYNC_STAGES cycles after the first clk edge that samples the new level.
- Pin falling → ie0 / t0_event: SYNC_STAGES+1 cycles; t0_event high for exactly one cycle.
- Pins must hold a level ≥ SYNC_STAGES+1 cycles for guaranteed detection; narrower pulses may be missed without error.
- Software write / ack: flag changes at the clk edge where the strobe is sampled, visible the next cycle.
- rst asserted mid-operation overrides everything on that edge, including a coincident fall.

## Structure
- Constants OC8051_SFR_TCON (8'h88), OC8051_SFR_B_TCON bit addresses 8'h89 / 8'h8B, and OC8051_RST_P0..P3 belong in the shared defines; the block uses the reset values for sync-stage reset.
- Natural sub-module: oc8051_sync_edge (one bit: SYNC_STAGES synchronizer plus prev flop, outputs level and fall); instantiated per bit, with the fall output left unused for non-monitored bits.
- Flag logic for IE0/IE1 is a small per-flag always block in the top module; no FSM beyond the flags.

## Test plan
- Reset: hold rst 3 cycles with all pins 0 → after release pN_in = 0xFF first, then 0x00 after SYNC_STAGES cycles; ie0/ie1/t0_event stay 0 (only a fall post-reset may set them).
- Edge mode: it0=1, P3.2 1→0 → ie0 = 1 exactly SYNC_STAGES+1 cycles later; pulse ie0_ack → ie0 = 0 next cycle; P3.2 staying 0 does not re-set.
- Level mode: it1=0, hold P3.3 low 10 cycles then high → ie1 high while low (delayed SYNC_STAGES+1), 0 after; ie1_ack mid-window has no effect.
- Collision: edge mode, fall on P3.2 arrives same cycle as ie0_ack and as bit write 0x89 bit_in=0 → ie0 = 1.
- Software: TCON byte write data_in=0x0A → ie0=1, ie1=1; bit write 0x8B=0 → ie1=0, ie0 unchanged.
- Counter strobes: toggle P3.4 at 1/8 clk rate for 5 periods → exactly 5 single-cycle t0_event pulses, zero on t1_event; 1-cycle glitch on P3.5 → no requirement, no X.

Source files
------------

// File: rtl/oc8051_port_sampler_pkg.sv
// Shared definitions for the 8051 port input sampler.
// Holds the TCON SFR address, the bit addresses of IE0/IE1, the port reset
// values and the small types used by the SFR-side interface and flag logic.
package oc8051_port_sampler_pkg;

  typedef logic [7:0] sfr_addr_t;

  // Decoded software write to one interrupt flag.
  typedef struct packed {
    logic we;
    logic val;
  } flag_wr_t;

  localparam sfr_addr_t OC8051_SFR_TCON       = 8'h88;
  localparam sfr_addr_t OC8051_SFR_B_TCON_IE0 = 8'h89;
  localparam sfr_addr_t OC8051_SFR_B_TCON_IE1 = 8'h8B;

  // Port latches come out of reset as all ones.
  localparam logic [7:0] OC8051_RST_P0 = 8'hFF;
  localparam logic [7:0] OC8051_RST_P1 = 8'hFF;
  localparam logic [7:0] OC8051_RST_P2 = 8'hFF;
  localparam logic [7:0] OC8051_RST_P3 = 8'hFF;

endpackage

// File: rtl/oc8051_port_sampler_if.sv
// SFR-side bus of the port sampler.
// master: SFR write path, TCON mode bits and interrupt controller acks; it
//         receives the IE0/IE1 flags and the T0/T1 counter strobes.
// slave : the port sampler itself.
interface oc8051_port_sampler_if;
  import oc8051_port_sampler_pkg::*;

  logic      it0;
  logic      it1;
  logic      wr;
  logic      wr_bit;
  sfr_addr_t wr_addr;
  logic [7:0] data_in;
  logic      bit_in;
  logic      ie0_ack;
  logic      ie1_ack;
  logic      ie0;
  logic      ie1;
  logic      t0_event;
  logic      t1_event;

  modport master (
    output it0, it1, wr, wr_bit, wr_addr, data_in, bit_in, ie0_ack, ie1_ack,
    input  ie0, ie1, t0_event, t1_event
  );

  modport slave (
    input  it0, it1, wr, wr_bit, wr_addr, data_in, bit_in, ie0_ack, ie1_ack,
    output ie0, ie1, t0_event, t1_event
  );

endinterface

// File: rtl/oc8051_sync_edge.sv
// One pin bit: SYNC_STAGES-deep synchronizer followed by a "prev" flop used
// for falling-edge detection.
// Ports: clk, rst (sync, active-high), pin (async level),
//        level (synchronized value), fall (prev high, level now low).
module oc8051_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev_p;

  // Every stage, including prev, resets to the port reset level so that
  // releasing reset never produces a phantom edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= {SYNC_STAGES{RST_VAL}};
      prev_p <= RST_VAL;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], pin};
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign level = sync_p[SYNC_STAGES-1];
  assign fall  = prev_p & ~level;

endmodule

// File: rtl/oc8051_port_sampler.sv
// Input side of the 8051 parallel ports.
// Synchronizes P0-P3 pin levels, presents them to the SFR read path, and
// derives the P3 alternate-function events: IE0/IE1 flags (level or
// falling-edge mode per IT0/IT1) and T0/T1 counter strobes.
// Ports: clk, rst (sync, active-high)
//        p0_pin..p3_pin  raw asynchronous pin levels
//        p0_in..p3_in    synchronized pin values
//        sfr             SFR write / mode / ack bus, returns ie0, ie1,
//                        t0_event, t1_event
module oc8051_port_sampler
  import oc8051_port_sampler_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] p0_pin,
  input  logic [7:0] p1_pin,
  input  logic [7:0] p2_pin,
  input  logic [7:0] p3_pin,
  output logic [7:0] p0_in,
  output logic [7:0] p1_in,
  output logic [7:0] p2_in,
  output logic [7:0] p3_in,
  oc8051_port_sampler_if.slave sfr
);

  localparam logic [31:0] RST_VEC = {OC8051_RST_P3, OC8051_RST_P2,
                                     OC8051_RST_P1, OC8051_RST_P0};

  logic [31:0] pins;
  logic [31:0] levels;
  logic [31:0] falls;

  assign pins = {p3_pin, p2_pin, p1_pin, p0_pin};

  for (genvar g = 0; g < 32; g++) begin : g_bit
    oc8051_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (RST_VEC[g])
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .pin   (pins[g]),
      .level (levels[g]),
      .fall  (falls[g])
    );
  end

  assign p0_in = levels[7:0];
  assign p1_in = levels[15:8];
  assign p2_in = levels[23:16];
  assign p3_in = levels[31:24];

  // Only P3.2..P3.5 feed edge-sensitive logic; other fall outputs are dropped
  // and their prev flops disappear in synthesis.
  logic unused_fall;
  assign unused_fall = ^{falls[31:30], falls[25:0]};

  logic fall_int0, fall_int1, fall_t0, fall_t1;
  assign fall_int0 = falls[26];
  assign fall_int1 = falls[27];
  assign fall_t0   = falls[28];
  assign fall_t1   = falls[29];

  // Software write decode: a TCON byte write carries both flags, a bit write
  // addresses exactly one.
  function automatic flag_wr_t decode_wr(input logic      wr,
                                         input logic      wr_bit,
                                         input sfr_addr_t addr,
                                         input sfr_addr_t bit_addr,
                                         input logic      byte_val,
                                         input logic      bit_val);
    flag_wr_t r;
    r.we  = 1'b0;
    r.val = 1'b0;
    if (wr && !wr_bit && addr == OC8051_SFR_TCON) begin
      r.we  = 1'b1;
      r.val = byte_val;
    end else if (wr && wr_bit && addr == bit_addr) begin
      r.we  = 1'b1;
      r.val = bit_val;
    end
    return r;
  endfunction

  // Next flag value. Level mode tracks the inverted pin every cycle, so acks
  // and writes vanish; edge mode gives the hardware fall priority so an
  // interrupt arriving with its own ack is never lost.
  function automatic logic next_flag(input logic     edge_mode,
                                     input logic     lvl,
                                     input logic     fell,
                                     input logic     ack,
                                     input flag_wr_t sw,
                                     input logic     cur);
    logic r;
    if (!edge_mode)  r = ~lvl;
    else if (fell)   r = 1'b1;
    else if (ack)    r = 1'b0;
    else if (sw.we)  r = sw.val;
    else             r = cur;
    return r;
  endfunction

  flag_wr_t sw0, sw1;
  assign sw0 = decode_wr(sfr.wr, sfr.wr_bit, sfr.wr_addr, OC8051_SFR_B_TCON_IE0,
                         sfr.data_in[1], sfr.bit_in);
  assign sw1 = decode_wr(sfr.wr, sfr.wr_bit, sfr.wr_addr, OC8051_SFR_B_TCON_IE1,
                         sfr.data_in[3], sfr.bit_in);

  logic ie0_p, ie1_p, t0_p, t1_p;

  // Flag / strobe register stage: one cycle after the synchronized level.
  always_ff @(posedge clk) begin
    if (rst) ie0_p <= 1'b0;
    else     ie0_p <= next_flag(sfr.it0, p3_in[2], fall_int0, sfr.ie0_ack, sw0, ie0_p);
  end

  always_ff @(posedge clk) begin
    if (rst) ie1_p <= 1'b0;
    else     ie1_p <= next_flag(sfr.it1, p3_in[3], fall_int1, sfr.ie1_ack, sw1, ie1_p);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t0_p <= 1'b0;
      t1_p <= 1'b0;
    end else begin
      t0_p <= fall_t0;
      t1_p <= fall_t1;
    end
  end

  assign sfr.ie0      = ie0_p;
  assign sfr.ie1      = ie1_p;
  assign sfr.t0_event = t0_p;
  assign sfr.t1_event = t1_p;

endmodule

// File: tb/tb_oc8051_port_sampler.sv
module tb_oc8051_port_sampler;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p0_pin, p1_pin, p2_pin, p3_pin;
  logic [7:0] p0_in, p1_in, p2_in, p3_in;

  oc8051_port_sampler_if sfr_if();

  oc8051_port_sampler #(.SYNC_STAGES(SS)) dut (
    .clk    (clk),
    .rst    (rst),
    .p0_pin (p0_pin),
    .p1_pin (p1_pin),
    .p2_pin (p2_pin),
    .p3_pin (p3_pin),
    .p0_in  (p0_in),
    .p1_in  (p1_in),
    .p2_in  (p2_in),
    .p3_in  (p3_in),
    .sfr    (sfr_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin words sampled at each edge; the synchronized level is the sample
  // taken SS-1 edges earlier. Events compare the level before an edge with
  // the one before that.
  logic [31:0] samp_q[$];
  logic [31:0] m_lvl, m_prv;
  logic        m_ie0, m_ie1, m_t0, m_t1;

  task automatic model_reset();
    samp_q.delete();
    for (int i = 0; i < SS; i++) samp_q.push_back(32'hFFFF_FFFF);
    m_lvl = 32'hFFFF_FFFF;
    m_prv = 32'hFFFF_FFFF;
    m_ie0 = 1'b0; m_ie1 = 1'b0; m_t0 = 1'b0; m_t1 = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] fell;
    logic we0, we1, v0, v1, tcon_byte;
    if (rst) begin
      model_reset();
    end else begin
      fell = m_prv & ~m_lvl;
      tcon_byte = sfr_if.wr && !sfr_if.wr_bit && sfr_if.wr_addr == 8'h88;
      we0 = tcon_byte || (sfr_if.wr && sfr_if.wr_bit && sfr_if.wr_addr == 8'h89);
      we1 = tcon_byte || (sfr_if.wr && sfr_if.wr_bit && sfr_if.wr_addr == 8'h8B);
      v0  = tcon_byte ? sfr_if.data_in[1] : sfr_if.bit_in;
      v1  = tcon_byte ? sfr_if.data_in[3] : sfr_if.bit_in;
      m_ie0 = sfr_if.it0 ? (fell[26] | (~sfr_if.ie0_ack & (we0 ? v0 : m_ie0))) : ~m_lvl[26];
      m_ie1 = sfr_if.it1 ? (fell[27] | (~sfr_if.ie1_ack & (we1 ? v1 : m_ie1))) : ~m_lvl[27];
      m_t0 = fell[28];
      m_t1 = fell[29];
      samp_q.push_back({p3_pin, p2_pin, p1_pin, p0_pin});
      void'(samp_q.pop_front());
      m_prv = m_lvl;
      m_lvl = samp_q[0];
    end
  endtask

  // One clock: model advances with the DUT, outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ports_vs_model", {32'd0, p3_in, p2_in, p1_in, p0_in}, {32'd0, m_lvl});
    chk("flags_vs_model", {60'd0, sfr_if.ie0, sfr_if.ie1, sfr_if.t0_event, sfr_if.t1_event},
        {60'd0, m_ie0, m_ie1, m_t0, m_t1});
  endtask

  task automatic idle_bus();
    sfr_if.wr = 1'b0; sfr_if.wr_bit = 1'b0; sfr_if.wr_addr = 8'h00;
    sfr_if.data_in = 8'h00; sfr_if.bit_in = 1'b0;
    sfr_if.ie0_ack = 1'b0; sfr_if.ie1_ack = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       it0, it1, wr, wrb;
    logic [7:0] addr, data;
    logic       bitv, a0, a1;
    logic [7:0] p3;
    logic [3:0] exp;   // {ie0, ie1, t0_event, t1_event} after the edge
  } vec_t;

  function automatic vec_t mk(input logic it0, input logic it1, input logic wr,
                              input logic wrb, input logic [7:0] addr,
                              input logic [7:0] data, input logic bitv,
                              input logic a0, input logic a1,
                              input logic [7:0] p3, input logic [3:0] exp);
    vec_t v;
    v.it0 = it0; v.it1 = it1; v.wr = wr; v.wrb = wrb; v.addr = addr;
    v.data = data; v.bitv = bitv; v.a0 = a0; v.a1 = a1; v.p3 = p3; v.exp = exp;
    return v;
  endfunction

  localparam int NV = 40;
  vec_t tbl[NV];

  int t0_cnt, t1_cnt;

  initial begin
    //          it0 it1 wr wb addr   data   bit a0 a1 p3     exp
    tbl[0]  = mk(1, 1, 1, 0, 8'h88, 8'h0A, 0, 0, 0, 8'hFF, 4'b1100);
    tbl[1]  = mk(1, 1, 1, 1, 8'h8B, 8'h00, 0, 0, 0, 8'hFF, 4'b1000);
    tbl[2]  = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 4'b0000);
    tbl[3]  = mk(1, 1, 1, 1, 8'h89, 8'h00, 1, 0, 0, 8'hFF, 4'b1000);
    tbl[4]  = mk(1, 1, 1, 0, 8'h88, 8'h00, 0, 0, 0, 8'hFF, 4'b0000);
    tbl[5]  = mk(1, 1, 1, 0, 8'h89, 8'hFF, 1, 0, 0, 8'hFF, 4'b0000);
    tbl[6]  = mk(1, 1, 1, 1, 8'h8A, 8'h00, 1, 0, 0, 8'hFF, 4'b0000);
    tbl[7]  = mk(1, 1, 1, 0, 8'h88, 8'hF5, 1, 0, 0, 8'hFF, 4'b0000);
    tbl[8]  = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFB, 4'b0000);
    tbl[9]  = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFB, 4'b0000);
    tbl[10] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFB, 4'b1000);
    tbl[11] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'hFB, 4'b0000);
    tbl[12] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFB, 4'b0000);
    tbl[13] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 4'b0000);
    tbl[14] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 4'b0000);
    tbl[15] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 4'b0000);
    tbl[16] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFB, 4'b0000);
    tbl[17] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFB, 4'b0000);
    tbl[18] = mk(1, 1, 1, 1, 8'h89, 8'h00, 0, 1, 0, 8'hFB, 4'b1000);
    tbl[19] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 4'b1000);
    tbl[20] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b1000);
    tbl[21] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b1000);
    tbl[22] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b1010);
    tbl[23] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b1000);
    tbl[24] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b1000);
    tbl[25] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hE7, 4'b1000);
    tbl[26] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hE7, 4'b1000);
    tbl[27] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hE7, 4'b1100);
    tbl[28] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'hE7, 4'b1100);
    tbl[29] = mk(1, 0, 1, 1, 8'h8B, 8'h00, 0, 0, 0, 8'hE7, 4'b1100);
    tbl[30] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b1100);
    tbl[31] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b1100);
    tbl[32] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b1000);
    tbl[33] = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b0000);
    tbl[34] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b0000);
    tbl[35] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hE7, 4'b0000);
    tbl[36] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hE7, 4'b0000);
    tbl[37] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hE7, 4'b0100);
    tbl[38] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hE7, 4'b0100);
    tbl[39] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'hEF, 4'b0100);

    // Reset with all pins low: ports read 0xFF first, then 0x00.
    model_reset();
    rst = 1'b1;
    p0_pin = 8'h00; p1_pin = 8'h00; p2_pin = 8'h00; p3_pin = 8'h00;
    sfr_if.it0 = 1'b1; sfr_if.it1 = 1'b1;
    idle_bus();
    repeat (3) step();
    chk("rst_ports", {32'd0, p3_in, p2_in, p1_in, p0_in}, 64'hFFFF_FFFF);
    chk("rst_flags", {60'd0, sfr_if.ie0, sfr_if.ie1, sfr_if.t0_event, sfr_if.t1_event}, 64'd0);
    rst = 1'b0;
    step();
    chk("rel1_ports", {32'd0, p3_in, p2_in, p1_in, p0_in}, 64'hFFFF_FFFF);
    chk("rel1_flags", {60'd0, sfr_if.ie0, sfr_if.ie1, sfr_if.t0_event, sfr_if.t1_event}, 64'd0);
    step();
    chk("rel2_ports", {32'd0, p3_in, p2_in, p1_in, p0_in}, 64'd0);
    chk("rel2_flags", {60'd0, sfr_if.ie0, sfr_if.ie1, sfr_if.t0_event, sfr_if.t1_event}, 64'd0);
    step();
    chk("rel3_flags", {60'd0, sfr_if.ie0, sfr_if.ie1, sfr_if.t0_event, sfr_if.t1_event}, 64'hF);
    step();
    chk("rel4_flags", {60'd0, sfr_if.ie0, sfr_if.ie1, sfr_if.t0_event, sfr_if.t1_event}, 64'hC);

    // Return pins high and clear both flags before the vector table.
    p0_pin = 8'hFF; p1_pin = 8'hFF; p2_pin = 8'hFF; p3_pin = 8'hFF;
    repeat (4) step();
    sfr_if.wr = 1'b1; sfr_if.wr_addr = 8'h88; sfr_if.data_in = 8'h00;
    step();
    idle_bus();
    step();
    chk("pre_table_flags", {62'd0, sfr_if.ie0, sfr_if.ie1}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      sfr_if.it0 = tbl[i].it0; sfr_if.it1 = tbl[i].it1;
      sfr_if.wr = tbl[i].wr; sfr_if.wr_bit = tbl[i].wrb;
      sfr_if.wr_addr = tbl[i].addr; sfr_if.data_in = tbl[i].data;
      sfr_if.bit_in = tbl[i].bitv;
      sfr_if.ie0_ack = tbl[i].a0; sfr_if.ie1_ack = tbl[i].a1;
      p3_pin = tbl[i].p3;
      step();
      chk($sformatf("vec%0d", i),
          {60'd0, sfr_if.ie0, sfr_if.ie1, sfr_if.t0_event, sfr_if.t1_event},
          {60'd0, tbl[i].exp});
    end
    idle_bus();

    // Reset landing on the same edge as a pending P3.2 fall wins.
    p3_pin = 8'hFF;
    repeat (3) step();
    p3_pin = 8'hFB;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rst_vs_fall_ie0", {63'd0, sfr_if.ie0}, 64'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_fall_ie0", {63'd0, sfr_if.ie0}, 64'd1);

    // Counter strobes: P3.4 period of 8 clocks, five falling edges.
    p3_pin = 8'hFF;
    repeat (4) step();
    t0_cnt = 0; t1_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      p3_pin = (k < 40 && (k % 8) < 4) ? 8'hEF : 8'hFF;
      step();
      t0_cnt += int'(sfr_if.t0_event);
      t1_cnt += int'(sfr_if.t1_event);
    end
    chk("t0_pulse_count", 64'(t0_cnt), 64'd5);
    chk("t1_pulse_count", 64'(t1_cnt), 64'd0);

    // Single-cycle glitch on P3.5: detection optional, output must stay defined.
    p3_pin = 8'hDF;
    step();
    p3_pin = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_glitch_known", {63'd0, $isunknown(sfr_if.t1_event)}, 64'd0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      p0_pin = 8'($urandom); p1_pin = 8'($urandom); p2_pin = 8'($urandom);
      if ($urandom_range(0, 3) == 0) p3_pin = 8'($urandom);
      if ($urandom_range(0, 15) == 0) sfr_if.it0 = ~sfr_if.it0;
      if ($urandom_range(0, 15) == 0) sfr_if.it1 = ~sfr_if.it1;
      sfr_if.wr = ($urandom_range(0, 3) == 0);
      sfr_if.wr_bit = 1'($urandom);
      case ($urandom_range(0, 4))
        0: sfr_if.wr_addr = 8'h88;
        1: sfr_if.wr_addr = 8'h89;
        2: sfr_if.wr_addr = 8'h8B;
        3: sfr_if.wr_addr = 8'h8A;
        default: sfr_if.wr_addr = 8'($urandom);
      endcase
      sfr_if.data_in = 8'($urandom);
      sfr_if.bit_in = 1'($urandom);
      sfr_if.ie0_ack = ($urandom_range(0, 7) == 0);
      sfr_if.ie1_ack = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
